// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder
//   Finds an ARM rotated-immediate encoding {Rot4, Imm8} for a 32-bit constant
//   such that Const == ROR(Imm8, 2*Rot4). The search tries one rotation per
//   cycle, smallest Rot4 first. Valid/ready handshakes are used on both the
//   request side and the result side.
module arm_imm_encoder #(
  parameter int MAX_ROT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Const,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Found,
  output logic [3:0]  Rot4,
  output logic [7:0]  Imm8,
  output logic [11:0] Enc12
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // The counter is 4 bits wide, so it can never step past the last rotation.
  localparam logic [3:0] LAST_ROT = 4'(MAX_ROT);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_const;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_found;
  logic [3:0]  r_rot4;
  logic [7:0]  r_imm8;

  logic [4:0]  w_shamt;
  logic [31:0] w_rot;

  // Rotate a 32-bit word left. Taking the upper half of the doubled word
  // avoids any out-of-range shift when the amount is zero.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] w;
    w = {v, v} << sh;
    return w[63:32];
  endfunction

  // Undo the candidate rotation: if the result fits in 8 bits, that is Imm8.
  assign w_shamt = {r_cnt, 1'b0};
  assign w_rot   = rol32(r_const, w_shamt);

  // Search FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_const     <= 32'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_found     <= 1'b0;
      r_rot4      <= 4'd0;
      r_imm8      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            r_const    <= Const;
            r_cnt      <= 4'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_rot[31:8] == 24'd0) begin
            r_found     <= 1'b1;
            r_rot4      <= r_cnt;
            r_imm8      <= w_rot[7:0];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_cnt == LAST_ROT) begin
            r_found     <= 1'b0;
            r_rot4      <= 4'd0;
            r_imm8      <= 8'd0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          // Returning to IDLE first guarantees no same-cycle turnaround.
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign Found    = r_found;
  assign Rot4     = r_rot4;
  assign Imm8     = r_imm8;
  assign Enc12    = {r_rot4, r_imm8};

endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder
//   Scoreboarded bench for arm_imm_encoder: expected encodings and latencies
//   are queued when a request is driven and compared when the result appears.
module tb_arm_imm_encoder;

  localparam int MAX_ROT = 15;
  localparam int WAIT_LIMIT = 40;

  typedef struct {
    logic       found;
    logic [3:0] rot;
    logic [7:0] imm;
    int         lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] Const = 32'd0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic        Found;
  logic [3:0]  Rot4;
  logic [7:0]  Imm8;
  logic [11:0] Enc12;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  arm_imm_encoder #(.MAX_ROT(MAX_ROT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .InValid(InValid), .InReady(InReady), .Const(Const),
    .OutValid(OutValid), .OutReady(OutReady),
    .Found(Found), .Rot4(Rot4), .Imm8(Imm8), .Enc12(Enc12)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ror32(input logic [31:0] v, input int sh);
    logic [63:0] w;
    w = {v, v} >> (sh % 32);
    return w[31:0];
  endfunction

  // Golden model: smallest r whose 8-bit candidate rotates back to the constant.
  function automatic exp_t model(input logic [31:0] c);
    exp_t e;
    logic [31:0] t;
    e.found = 1'b0; e.rot = 4'd0; e.imm = 8'd0; e.lat = MAX_ROT + 1;
    t = c;
    for (int r = 0; r <= MAX_ROT; r++) begin
      if (ror32({24'd0, t[7:0]}, 2 * r) == c) begin
        e.found = 1'b1; e.rot = r[3:0]; e.imm = t[7:0]; e.lat = r + 1;
        return e;
      end
      t = {t[29:0], t[31:30]};
    end
    return e;
  endfunction

  // Drive one request from IDLE, wait (bounded) for the result, then consume it.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_req(input logic [31:0] c, output logic [24:0] obs, output int lat);
    sb.push_back(model(c));
    InValid = 1'b1; Const = c;
    @(posedge CLK); #1;
    InValid = 1'b0; Const = $urandom;
    lat = 0;
    while (!OutValid && lat < WAIT_LIMIT) begin
      @(posedge CLK); #1; lat++;
    end
    obs = {Found, Rot4, Imm8, Enc12};
    OutReady = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({OutValid, Found, Rot4, Imm8, Enc12} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {OutValid, Found, Rot4, Imm8, Enc12});
    end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: InReady=%b OutValid=%b required 1/0", InReady, OutValid);
    end
  endtask

  task automatic test_basic;
    logic [31:0] cs [6] = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_000F,
                             32'h0000_0104, 32'h0000_0101, 32'h0000_0000};
    logic [12:0] fixed [6] = '{{1'b1, 12'h0FF}, {1'b1, 12'h4FF}, {1'b1, 12'h2FF},
                                {1'b1, 12'hF41}, {1'b0, 12'h000}, {1'b1, 12'h000}};
    int   lats [6] = '{1, 5, 3, 16, 16, 1};
    logic [24:0] obs;
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      run_req(cs[i], obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== {e.found, e.rot, e.imm, e.rot, e.imm}) begin
        n_fail++;
        $display("FAIL basic_model c=%h: got %h required %h", cs[i], obs, {e.found, e.rot, e.imm, e.rot, e.imm});
      end
      n_checks++;
      if ({obs[24], obs[11:0]} !== fixed[i] || lat !== lats[i]) begin
        n_fail++;
        $display("FAIL basic_fixed c=%h: got found/enc %h lat %0d required %h lat %0d",
                 cs[i], {obs[24], obs[11:0]}, lat, fixed[i], lats[i]);
      end
      n_checks++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL basic_latency c=%h: got %0d required %0d", cs[i], lat, e.lat);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [24:0] held;
    int   lat;
    exp_t e;
    sb.push_back(model(32'hF000_000F));
    InValid = 1'b1; Const = 32'hF000_000F;
    @(posedge CLK); #1;
    InValid = 1'b0;
    n_checks++;
    if (InReady !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL search_handshake: InReady=%b OutValid=%b required 0/0", InReady, OutValid);
    end
    lat = 0;
    while (!OutValid && lat < WAIT_LIMIT) begin
      @(posedge CLK); #1; lat++;
    end
    held = {Found, Rot4, Imm8, Enc12};
    e = sb.pop_front();
    n_checks++;
    if (held !== {e.found, e.rot, e.imm, e.rot, e.imm} || lat !== e.lat) begin
      n_fail++;
      $display("FAIL bp_result: got %h lat %0d required %h lat %0d",
               held, lat, {e.found, e.rot, e.imm, e.rot, e.imm}, e.lat);
    end
    // A competing request while the result is stalled must be ignored.
    InValid = 1'b1; Const = 32'h0000_00FF;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || {Found, Rot4, Imm8, Enc12} !== held) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: OutValid=%b InReady=%b out=%h required 1/0/%h",
                 i, OutValid, InReady, {Found, Rot4, Imm8, Enc12}, held);
      end
    end
    OutReady = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b0; InValid = 1'b0;
    n_checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || {Found, Rot4, Imm8, Enc12} !== held) begin
      n_fail++;
      $display("FAIL bp_release: OutValid=%b InReady=%b out=%h required 0/1/%h",
               OutValid, InReady, {Found, Rot4, Imm8, Enc12}, held);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_turnaround: InReady=%b required 1", InReady);
    end
  endtask

  task automatic test_reset_abort;
    logic [24:0] obs;
    int   lat;
    exp_t e;
    InValid = 1'b1; Const = 32'h0000_0104;
    @(posedge CLK); #1;
    InValid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Found !== 1'b0 || Enc12 !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_reset: OutValid=%b InReady=%b Found=%b Enc12=%h required 0/1/0/000",
               OutValid, InReady, Found, Enc12);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_req(32'h0000_00FF, obs, lat);
    e = sb.pop_front();
    n_checks++;
    if (obs !== {e.found, e.rot, e.imm, e.rot, e.imm} || lat !== e.lat) begin
      n_fail++;
      $display("FAIL abort_recover: got %h lat %0d required %h lat %0d",
               obs, lat, {e.found, e.rot, e.imm, e.rot, e.imm}, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] cs [3] = '{32'h0003_FC00, 32'h8000_0000, 32'hABCD_1234};
    logic [24:0] obs;
    int   lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_req(cs[i], obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== {e.found, e.rot, e.imm, e.rot, e.imm} || lat !== e.lat) begin
        n_fail++;
        $display("FAIL b2b c=%h: got %h lat %0d required %h lat %0d",
                 cs[i], obs, lat, {e.found, e.rot, e.imm, e.rot, e.imm}, e.lat);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] c;
    logic [24:0] obs;
    int   lat;
    exp_t e;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) c = $urandom;
      else c = ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
      run_req(c, obs, lat);
      e = sb.pop_front();
      n_checks++;
      if (obs !== {e.found, e.rot, e.imm, e.rot, e.imm} || lat !== e.lat) begin
        n_fail++;
        $display("FAIL rand_model c=%h: got %h lat %0d required %h lat %0d",
                 c, obs, lat, {e.found, e.rot, e.imm, e.rot, e.imm}, e.lat);
      end
      if (obs[24]) begin
        n_checks++;
        if (ror32({24'd0, obs[19:12]}, 2 * int'(obs[23:20])) !== c) begin
          n_fail++;
          $display("FAIL rand_roundtrip c=%h: enc %h decodes to %h",
                   c, obs[11:0], ror32({24'd0, obs[19:12]}, 2 * int'(obs[23:20])));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
